// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request, shared-ALU and response signals of the ALU arbiter
interface alu_req_arbiter_if #(
   parameter int OPW  = 4,
   parameter int RESW = 20
);
   logic            req0_valid;
   logic            req0_ready;
   logic [OPW-1:0]  req0_op1;
   logic [OPW-1:0]  req0_op2;
   logic            req0_operation;
   logic            req0_sign;
   logic            req1_valid;
   logic            req1_ready;
   logic [OPW-1:0]  req1_op1;
   logic [OPW-1:0]  req1_op2;
   logic            req1_operation;
   logic            req1_sign;
   logic [OPW-1:0]  alu_op1;
   logic [OPW-1:0]  alu_op2;
   logic            alu_operation;
   logic            alu_sign;
   logic [RESW-1:0] alu_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [RESW-1:0] rsp_result;
   logic            busy;

   modport slave (
      input  req0_valid, req0_op1, req0_op2, req0_operation, req0_sign,
      input  req1_valid, req1_op1, req1_op2, req1_operation, req1_sign,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready,
      output alu_op1, alu_op2, alu_operation, alu_sign,
      output rsp_valid, rsp_id, rsp_result, busy
   );

   modport master (
      output req0_valid, req0_op1, req0_op2, req0_operation, req0_sign,
      output req1_valid, req1_op1, req1_op2, req1_operation, req1_sign,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_op1, alu_op2, alu_operation, alu_sign,
      input  rsp_valid, rsp_id, rsp_result, busy
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one combinational mini ALU between two requesters
module alu_req_arbiter #(
   parameter int OPW  = 4,
   parameter int RESW = 20
) (
   input logic              clk,
   input logic              rst_n,
   alu_req_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            last_grant;
   logic            grant;
   logic            ready0;
   logic            ready1;
   logic            take;
   logic [OPW-1:0]  sel_op1;
   logic [OPW-1:0]  sel_op2;
   logic            sel_operation;
   logic            sel_sign;
   logic [OPW-1:0]  alu_op1_q;
   logic [OPW-1:0]  alu_op2_q;
   logic            alu_operation_q;
   logic            alu_sign_q;
   logic            rsp_valid_q;
   logic            rsp_id_q;
   logic [RESW-1:0] rsp_result_q;

   // Readies are gated by rst_n so nothing can handshake while reset is held.
   always_comb begin
      state_nxt = state;
      grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
      ready0    = rst_n && (state == IDLE) && bus.req0_valid && !grant;
      ready1    = rst_n && (state == IDLE) && bus.req1_valid && grant;
      take      = ready0 || ready1;
      case (state)
         IDLE:    if (take) state_nxt = EXEC;
         EXEC:    state_nxt = CAPT;
         CAPT:    state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sel_op1       = grant ? bus.req1_op1       : bus.req0_op1;
   assign sel_op2       = grant ? bus.req1_op2       : bus.req0_op2;
   assign sel_operation = grant ? bus.req1_operation : bus.req0_operation;
   assign sel_sign      = grant ? bus.req1_sign      : bus.req0_sign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op1_q       <= '0;
         alu_op2_q       <= '0;
         alu_operation_q <= 1'b0;
         alu_sign_q      <= 1'b0;
         last_grant      <= 1'b1;
         rsp_id_q        <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_result_q    <= '0;
      end else begin
         if (take) begin
            alu_op1_q       <= sel_op1;
            alu_op2_q       <= sel_op2;
            alu_operation_q <= sel_operation;
            alu_sign_q      <= sel_sign;
            rsp_id_q        <= grant;
            last_grant      <= grant;
         end
         if (state == CAPT) begin
            rsp_result_q <= bus.alu_result;
            rsp_valid_q  <= 1'b1;
         end
         if ((state == RESP) && bus.rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req0_ready    = ready0;
   assign bus.req1_ready    = ready1;
   assign bus.alu_op1       = alu_op1_q;
   assign bus.alu_op2       = alu_op2_q;
   assign bus.alu_operation = alu_operation_q;
   assign bus.alu_sign      = alu_sign_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_result    = rsp_result_q;
   assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter against a transaction-level model
module tb_alu_req_arbiter;
   localparam int OPW  = 4;
   localparam int RESW = 20;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_req_arbiter_if #(.OPW(OPW), .RESW(RESW)) bus ();
   alu_req_arbiter #(.OPW(OPW), .RESW(RESW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic logic [19:0] alu_fn(logic [3:0] a, logic [3:0] b, logic op, logic sg);
      logic [19:0] ea;
      logic [19:0] eb;
      ea = {16'd0, a};
      eb = {16'd0, b};
      if (!op) return sg ? ea - eb : ea + eb;
      return sg ? ea >> b : ea << b;
   endfunction

   assign bus.alu_result = alu_fn(bus.alu_op1, bus.alu_op2, bus.alu_operation, bus.alu_sign);

   function automatic int ref_fn(int a, int b, int op, int sg);
      int m;
      m = 1 << 20;
      if (op == 0) return (sg != 0) ? (a + m - b) % m : a + b;
      return (sg != 0) ? a / (1 << b) : (a * (1 << b)) % m;
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: an op accepted in cycle a keeps the block busy until its response
   // is consumed; its response is visible from cycle a+3 onward.
   int   cyc     = 0;
   bit   m_out   = 0;
   int   m_acc   = 0;
   bit   m_last  = 1;
   bit   m_id    = 0;
   int   m_res   = 0;
   int   m_a1    = 0;
   int   m_a2    = 0;
   int   m_aop   = 0;
   int   m_asg   = 0;
   int   w0      = 0;
   int   w1      = 0;
   int   acc_cnt = 0;
   int   rsp_cnt = 0;
   int   disc    = 0;
   int   order[$];

   always @(negedge clk) begin : compare
      bit v0, v1, g, e_r0, e_r1, e_rv;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      if (!rst_n) begin
         check("rst_rsp_valid", bus.rsp_valid, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_ready0", bus.req0_ready, 0);
         check("rst_ready1", bus.req1_ready, 0);
         check("rst_alu", {bus.alu_op1, bus.alu_op2, bus.alu_operation, bus.alu_sign}, 0);
         check("rst_rsp", {bus.rsp_id, bus.rsp_result}, 0);
         if (m_out) disc++;
         m_out = 0; m_last = 1; m_a1 = 0; m_a2 = 0; m_aop = 0; m_asg = 0;
         w0 = 0; w1 = 0;
      end else begin
         g    = (v0 && v1) ? !m_last : v1;
         e_r0 = !m_out && v0 && !g;
         e_r1 = !m_out && v1 && g;
         e_rv = m_out && (cyc >= m_acc + 3);
         check("ready0", bus.req0_ready, e_r0);
         check("ready1", bus.req1_ready, e_r1);
         check("busy", bus.busy, m_out);
         check("rsp_valid", bus.rsp_valid, e_rv);
         check("alu_ops", {bus.alu_op1, bus.alu_op2, bus.alu_operation, bus.alu_sign},
               {4'(m_a1), 4'(m_a2), 1'(m_aop), 1'(m_asg)});
         if (e_rv) begin
            check("rsp_id", bus.rsp_id, m_id);
            check("rsp_result", bus.rsp_result, m_res);
         end
         if (!bus.busy) begin
            if (v0 && !bus.req0_ready) begin w0++; check("fair0", w0 <= 1, 1); end
            else if (bus.req0_ready) w0 = 0;
            if (v1 && !bus.req1_ready) begin w1++; check("fair1", w1 <= 1, 1); end
            else if (bus.req1_ready) w1 = 0;
         end
         if (v0 && bus.req0_ready) acc_cnt++;
         if (v1 && bus.req1_ready) acc_cnt++;
         if (bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
         if (e_r0 || e_r1) begin
            m_out  = 1;
            m_acc  = cyc;
            m_last = g;
            m_id   = g;
            m_a1   = g ? int'(bus.req1_op1) : int'(bus.req0_op1);
            m_a2   = g ? int'(bus.req1_op2) : int'(bus.req0_op2);
            m_aop  = g ? int'(bus.req1_operation) : int'(bus.req0_operation);
            m_asg  = g ? int'(bus.req1_sign) : int'(bus.req0_sign);
            m_res  = ref_fn(m_a1, m_a2, m_aop, m_asg);
         end else if (e_rv && bus.rsp_ready) begin
            m_out = 0;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int n, input int a, input int b, input int op, input int sg);
      if (n == 0) begin
         bus.req0_valid = 1'b1; bus.req0_op1 = 4'(a); bus.req0_op2 = 4'(b);
         bus.req0_operation = 1'(op); bus.req0_sign = 1'(sg);
      end else begin
         bus.req1_valid = 1'b1; bus.req1_op1 = 4'(a); bus.req1_op2 = 4'(b);
         bus.req1_operation = 1'(op); bus.req1_sign = 1'(sg);
      end
   endtask

   task automatic issue(input int n, input int a, input int b, input int op, input int sg);
      int k;
      bit got;
      tick();
      set_req(n, a, b, op, sg);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         got = (n == 0) ? bus.req0_ready : bus.req1_ready;
      end while (!got && k < 50);
      check("issue_granted", got, 1);
      tick();
      if (n == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.rsp_valid && k < 30);
      check("rsp_arrives", bus.rsp_valid, 1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.busy && k < 50);
      check("drains_idle", bus.busy, 0);
   endtask

   task automatic run_traffic(input int n_ops, input int pv, input int pr);
      int nacc;
      int it;
      bit a0;
      bit a1;
      nacc = 0; it = 0; a0 = 0; a1 = 0;
      order.delete();
      while (nacc < n_ops && it < n_ops * 40 + 100) begin
         tick();
         if (a0) bus.req0_valid = 1'b0;
         if (a1) bus.req1_valid = 1'b0;
         if (!bus.req0_valid && $urandom_range(0, 99) < pv)
            set_req(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
         if (!bus.req1_valid && $urandom_range(0, 99) < pv)
            set_req(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
         bus.rsp_ready = ($urandom_range(0, 99) < pr);
         @(negedge clk);
         a0 = bus.req0_valid && bus.req0_ready;
         a1 = bus.req1_valid && bus.req1_ready;
         if (a0) order.push_back(0);
         if (a1) order.push_back(1);
         nacc += int'(a0) + int'(a1);
         it++;
      end
      check("traffic_done", nacc >= n_ops, 1);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      wait_idle();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int k;
      rst_n = 1'b1;
      bus.req0_valid = 0; bus.req0_op1 = 0; bus.req0_op2 = 0; bus.req0_operation = 0; bus.req0_sign = 0;
      bus.req1_valid = 0; bus.req1_op1 = 0; bus.req1_op2 = 0; bus.req1_operation = 0; bus.req1_sign = 0;
      bus.rsp_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // single req0: 3+4, response three cycles after the ready cycle
      issue(0, 3, 4, 0, 0);
      wait_rsp(k);
      check("t1_latency", k, 3);
      check("t1_id", bus.rsp_id, 0);
      check("t1_result", bus.rsp_result, 7);
      @(negedge clk);
      check("t1_busy_after", bus.busy, 0);

      // req1 sub wraps, shift left zero-extends
      issue(1, 2, 5, 0, 1);
      wait_rsp(k);
      check("t2_id", bus.rsp_id, 1);
      check("t2_sub", bus.rsp_result, 20'hFFFFD);
      issue(1, 15, 4, 1, 0);
      wait_rsp(k);
      check("t2_shl", bus.rsp_result, 20'h000F0);
      wait_idle();

      // continuous contention alternates starting with requester 0
      run_traffic(8, 100, 100);
      for (int i = 0; i < 8; i++) check("t3_grant_order", order[i], i % 2);

      // stalled response holds and blocks a pending requester
      bus.rsp_ready = 1'b0;
      issue(0, 5, 6, 0, 0);
      set_req(1, 1, 1, 0, 0);
      wait_rsp(k);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_hold_valid", bus.rsp_valid, 1);
         check("t4_hold_result", bus.rsp_result, 11);
         check("t4_blocked", {bus.busy, bus.req1_ready}, 2'b10);
      end
      tick();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t4_next_grant", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      wait_idle();

      // reset during EXEC, then contention restarts with requester 0
      issue(0, 7, 7, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check("t5_exec_rsp_valid", bus.rsp_valid, 0);
      check("t5_exec_busy", bus.busy, 0);
      set_req(0, 9, 2, 0, 1);
      set_req(1, 3, 3, 1, 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("t5_first_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
      tick();
      bus.req0_valid = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.req1_ready && k < 30);
      check("t5_second_grant", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      wait_idle();

      // reset during RESP discards the held response
      bus.rsp_ready = 1'b0;
      issue(1, 4, 1, 1, 1);
      wait_rsp(k);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_resp_rsp_valid", bus.rsp_valid, 0);
      check("t5_resp_busy", bus.busy, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      repeat (4) @(negedge clk);

      // randomized traffic against the model
      run_traffic(1000, 50, 50);

      check("accepted_vs_responded", acc_cnt, rsp_cnt + disc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
